// File: rtl/bit_counter_pkg.sv
// rtl/bit_counter_pkg.sv - shared widths and types for the bit-counter unit
package bit_counter_pkg;

  localparam int BC_WIDTH = 10;
  localparam int BC_RES_W = 4;

  typedef logic [BC_WIDTH-1:0] bc_data_t;
  typedef logic [BC_RES_W-1:0] bc_count_t;

endpackage

// File: rtl/shift_reg_lr.sv
// rtl/shift_reg_lr.sv - loadable logical right-shift register with zero and LSB flags
module shift_reg_lr
  import bit_counter_pkg::*;
#(
  parameter int WIDTH = BC_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  input  logic             load,
  input  logic             shift,
  output logic [WIDTH-1:0] q,
  output logic             is_zero,
  output logic             lsb
);

  logic [WIDTH-1:0] a_d;
  logic [WIDTH-1:0] a_q;

  // Next value: load beats shift, otherwise hold
  always_comb begin
    a_d = a_q;
    if (load) begin
      a_d = d;
    end else if (shift) begin
      a_d = {1'b0, a_q[WIDTH-1:1]};
    end
  end

  // Operand register, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
    end else begin
      a_q <= a_d;
    end
  end

  // Status flags depend on the register only, never on the commands
  always_comb begin
    q       = a_q;
    is_zero = (a_q == '0);
    lsb     = a_q[0];
  end

endmodule

// File: rtl/bit_count_datapath.sv
// rtl/bit_count_datapath.sv - operand shifter and result counter driven by an external controller
module bit_count_datapath
  import bit_counter_pkg::*;
#(
  parameter int WIDTH = BC_WIDTH,
  parameter int RES_W = BC_RES_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_a,
  input  logic             shift_a,
  input  logic             inc_result,
  input  logic             res_eq_zero,
  output logic             a_eq_zero,
  output logic             a_lsb,
  output logic [RES_W-1:0] result
);

  // Operand register kept under the name A so it can be probed from outside
  logic [WIDTH-1:0] A;

  logic [RES_W-1:0] result_d;
  logic [RES_W-1:0] result_q;

  shift_reg_lr #(
    .WIDTH(WIDTH)
  ) u_shift_reg (
    .clk    (clk),
    .rst_n  (reset),
    .d      (data_in),
    .load   (load_a),
    .shift  (shift_a),
    .q      (A),
    .is_zero(a_eq_zero),
    .lsb    (a_lsb)
  );

  // Next count: clear beats increment; increment wraps naturally
  always_comb begin
    result_d = result_q;
    if (res_eq_zero) begin
      result_d = '0;
    end else if (inc_result) begin
      result_d = result_q + RES_W'(1);
    end
  end

  // Result register, cleared asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_q <= '0;
    end else begin
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_bit_count_datapath.sv
// tb/tb_bit_count_datapath.sv - directed self-checking bench for bit_count_datapath
module tb_bit_count_datapath;
  import bit_counter_pkg::*;

  logic      clk;
  logic      reset;
  bc_data_t  data_in;
  logic      load_a;
  logic      shift_a;
  logic      inc_result;
  logic      res_eq_zero;
  logic      a_eq_zero;
  logic      a_lsb;
  bc_count_t result;

  int n_checks;
  int n_fails;

  bit_count_datapath dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .load_a     (load_a),
    .shift_a    (shift_a),
    .inc_result (inc_result),
    .res_eq_zero(res_eq_zero),
    .a_eq_zero  (a_eq_zero),
    .a_lsb      (a_lsb),
    .result     (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    load_a      = 1'b0;
    shift_a     = 1'b0;
    inc_result  = 1'b0;
    res_eq_zero = 1'b0;
  endtask

  task automatic check_state(input string tag, input logic [9:0] exp_a, input logic [3:0] exp_res);
    check({tag, ".A"}, 32'(dut.A), 32'(exp_a));
    check({tag, ".result"}, 32'(result), 32'(exp_res));
    check({tag, ".a_eq_zero"}, 32'(a_eq_zero), 32'(exp_a == 10'd0));
    check({tag, ".a_lsb"}, 32'(a_lsb), 32'(exp_a[0]));
  endtask

  // Load an operand, clear result, then run the controller's count loop
  task automatic count_run(input logic [9:0] operand);
    data_in     = operand;
    load_a      = 1'b1;
    res_eq_zero = 1'b1;
    tick();
    idle();
    for (int i = 0; i < 10; i++) begin
      shift_a    = 1'b1;
      inc_result = a_lsb;
      tick();
    end
    idle();
  endtask

  logic [9:0] seq_a [0:9];

  initial begin
    n_checks = 0;
    n_fails  = 0;
    data_in  = '0;
    idle();
    reset = 1'b0;

    // Reset held with random commands
    for (int i = 0; i < 4; i++) begin
      data_in     = 10'($urandom);
      load_a      = 1'($urandom);
      shift_a     = 1'($urandom);
      inc_result  = 1'($urandom);
      res_eq_zero = 1'($urandom);
      tick();
    end
    check_state("in_reset", 10'h000, 4'd0);
    idle();
    reset = 1'b1;
    tick();
    tick();
    check_state("post_reset", 10'h000, 4'd0);

    // Count 0x015, checking A after each shift
    seq_a[0] = 10'h00A; seq_a[1] = 10'h005; seq_a[2] = 10'h002; seq_a[3] = 10'h001;
    for (int i = 4; i < 10; i++) seq_a[i] = 10'h000;
    data_in     = 10'b0000010101;
    load_a      = 1'b1;
    res_eq_zero = 1'b1;
    tick();
    idle();
    check("load_015.A", 32'(dut.A), 32'h015);
    check("load_015.a_eq_zero", 32'(a_eq_zero), 32'd0);
    for (int i = 0; i < 10; i++) begin
      shift_a    = 1'b1;
      inc_result = a_lsb;
      tick();
      check($sformatf("shift%0d.A", i + 1), 32'(dut.A), 32'(seq_a[i]));
      check($sformatf("shift%0d.a_eq_zero", i + 1), 32'(a_eq_zero), 32'(i >= 4));
    end
    idle();
    check("count_015.result", 32'(result), 32'd3);

    // Clear beats increment
    res_eq_zero = 1'b1;
    inc_result  = 1'b1;
    tick();
    idle();
    check("clear_prio.result", 32'(result), 32'd0);

    // All ones
    count_run(10'h3FF);
    check_state("count_3ff", 10'h000, 4'd10);

    // Load beats shift
    data_in = 10'h0F0;
    load_a  = 1'b1;
    tick();
    idle();
    check("load_0f0.A", 32'(dut.A), 32'h0F0);
    data_in = 10'h2AA;
    load_a  = 1'b1;
    shift_a = 1'b1;
    tick();
    idle();
    check("load_prio.A", 32'(dut.A), 32'h2AA);
    check("load_prio.a_lsb", 32'(a_lsb), 32'd0);

    // Wrap after 17 increments from 0
    res_eq_zero = 1'b1;
    tick();
    idle();
    check("wrap_start", 32'(result), 32'd0);
    for (int i = 0; i < 17; i++) begin
      inc_result = 1'b1;
      tick();
      if (i == 15) check("wrap_16", 32'(result), 32'd0);
    end
    idle();
    check("wrap_17", 32'(result), 32'd1);

    // Asynchronous reset in the middle of a shift sequence
    data_in = 10'h3FF;
    load_a  = 1'b1;
    tick();
    load_a     = 1'b0;
    shift_a    = 1'b1;
    inc_result = 1'b1;
    tick();
    check("pre_async.A", 32'(dut.A), 32'h1FF);
    check("pre_async.result", 32'(result), 32'd2);
    #2;
    reset = 1'b0;
    #1;
    check_state("async_reset", 10'h000, 4'd0);
    tick();
    check_state("async_reset_held", 10'h000, 4'd0);
    idle();
    reset = 1'b1;
    tick();
    check_state("after_async", 10'h000, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
